// File: rtl/hack_pc.sv
// -----------------------------------------------------------------------------
// hack_pc : Hack CPU program counter stage
//
// Each advancing cycle it evaluates the Hack jump condition from the ALU flags
// and the C-instruction jump bits. It then loads the jump target, increments,
// or holds. A jump-to-self with unconditional jump bits (jmp=111) is the usual
// Hack halt idiom. It is latched as a sticky halt, which only reset clears.
//
// Ports
//   clk     in   1      rising-edge clock
//   reset   in   1      synchronous, active-high reset
//   en      in   1      advance enable; 0 = stall, all state holds
//   is_c    in   1      current instruction is a C-instruction
//   jmp     in   3      jump bits {j1,j2,j3} = {lt,eq,gt}
//   zr      in   1      ALU out == 0
//   ng      in   1      ALU out < 0
//   target  in   WIDTH  jump destination (A register value)
//   pc      out  WIDTH  current instruction address (registered)
//   taken   out  1      last advancing update was a jump (registered)
//   halted  out  1      sticky self-jump halt; this is the FSM state (HALT)
//
// Flow control: there is no valid/ready handshake. en is a plain stall
// qualifier. On an edge with en=0, nothing changes. On an edge with en=1, the
// inputs presented on that edge are consumed. The result is visible after
// that edge.
// -----------------------------------------------------------------------------
module hack_pc #(
  parameter int unsigned           WIDTH     = 16,
  parameter logic [WIDTH-1:0]      RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             is_c,
  input  logic [2:0]       jmp,
  input  logic             zr,
  input  logic             ng,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic             taken,
  output logic             halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state;

  logic jump;
  logic self_halt;

  // Hack jump condition, evaluated literally. The zr=ng=1 case is not a legal
  // ALU output, so it gets no special treatment. The gt term needs both flags
  // to be clear.
  always_comb begin
    jump = is_c & ((jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~zr & ~ng));
  end

  // Only the unconditional form counts as the halt idiom. A conditional
  // self-jump is an ordinary jump, because the flags may change later.
  always_comb begin
    self_halt = jump & (target == pc) & (jmp == 3'b111);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_VEC;
      taken <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (en) begin
            if (jump) begin
              pc    <= target;
              taken <= 1'b1;
              if (self_halt) state <= HALT;
            end else begin
              // Natural wrap from all-ones to zero; no flag is raised.
              pc    <= pc + WIDTH'(1);
              taken <= 1'b0;
            end
          end
        end
        HALT: begin
          // Frozen until reset, whatever en and the jump inputs are doing.
        end
        default: state <= RUN;
      endcase
    end
  end

  assign halted = (state == HALT);

endmodule

// File: tb/tb_hack_pc.sv
module tb_hack_pc;

  localparam int unsigned WIDTH = 16;
  localparam logic [WIDTH-1:0] RESET_VEC = 16'h0000;

  // ---------------- clock / reset block ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             is_c;
  logic [2:0]       jmp;
  logic             zr;
  logic             ng;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc;
  logic             taken;
  logic             halted;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  hack_pc #(.WIDTH(WIDTH), .RESET_VEC(RESET_VEC)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .is_c   (is_c),
    .jmp    (jmp),
    .zr     (zr),
    .ng     (ng),
    .target (target),
    .pc     (pc),
    .taken  (taken),
    .halted (halted)
  );

  // ---------------- driver tasks ----------------
  // Advance one edge and then sample 1 ns later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic c,
                       input logic [2:0] j, input logic z, input logic n,
                       input logic [WIDTH-1:0] t);
    reset  = r;
    en     = e;
    is_c   = c;
    jmp    = j;
    zr     = z;
    ng     = n;
    target = t;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (pc !== RESET_VEC) $display("FAIL reset_pc: got %h want %h", pc, RESET_VEC);
    else passed++;
    checks++;
    if (taken !== 1'b0) $display("FAIL reset_taken: got %b want 0", taken);
    else passed++;
    checks++;
    if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted);
    else passed++;
  endtask

  task automatic test_increment();
    logic [WIDTH-1:0] exp_pc;
    exp_pc = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 16'h0000);
      checks++;
      if (pc !== exp_pc || taken !== 1'b0 || halted !== 1'b0)
        $display("FAIL incr_%0d: got pc=%h taken=%b halted=%b want pc=%h taken=0 halted=0",
                 i, pc, taken, halted, exp_pc);
      else passed++;
      exp_pc = exp_pc + 16'h0001;
    end
  endtask

  task automatic test_jump_eq();
    // pc=3 -> unconditional jump to 5
    drive(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0005);
    checks++;
    if (pc !== 16'h0005 || taken !== 1'b1)
      $display("FAIL preload5: got pc=%h taken=%b want pc=0005 taken=1", pc, taken);
    else passed++;
    // JEQ with zr=1 -> taken
    drive(1'b0, 1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 16'h0040);
    checks++;
    if (pc !== 16'h0040 || taken !== 1'b1)
      $display("FAIL jeq_taken: got pc=%h taken=%b want pc=0040 taken=1", pc, taken);
    else passed++;
    // back to 5, then JEQ with ng=1 -> not taken
    drive(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0005);
    drive(1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 1'b1, 16'h0040);
    checks++;
    if (pc !== 16'h0006 || taken !== 1'b0)
      $display("FAIL jeq_not_taken: got pc=%h taken=%b want pc=0006 taken=0", pc, taken);
    else passed++;
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'hFFFF);
    checks++;
    if (pc !== 16'hFFFF) $display("FAIL preload_ffff: got pc=%h want ffff", pc);
    else passed++;
    drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (pc !== 16'h0000 || taken !== 1'b0 || halted !== 1'b0)
      $display("FAIL wrap: got pc=%h taken=%b halted=%b want pc=0000 taken=0 halted=0",
               pc, taken, halted);
    else passed++;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0077);
      checks++;
      if (pc !== 16'h0000 || taken !== 1'b0 || halted !== 1'b0)
        $display("FAIL stall_%0d: got pc=%h taken=%b halted=%b want pc=0000 taken=0 halted=0",
                 i, pc, taken, halted);
      else passed++;
    end
    drive(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0077);
    checks++;
    if (pc !== 16'h0077 || taken !== 1'b1)
      $display("FAIL stall_release: got pc=%h taken=%b want pc=0077 taken=1", pc, taken);
    else passed++;
    // taken=1 must also hold through a stall
    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (pc !== 16'h0077 || taken !== 1'b1)
      $display("FAIL stall_hold_taken: got pc=%h taken=%b want pc=0077 taken=1", pc, taken);
    else passed++;
    // reset during a stall still resets
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (pc !== RESET_VEC || taken !== 1'b0)
      $display("FAIL reset_mid_stall: got pc=%h taken=%b want pc=%h taken=0", pc, taken, RESET_VEC);
    else passed++;
    // leave pc at 0x0077 for the halt test
    drive(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0077);
  endtask

  task automatic test_halt();
    drive(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0010);
    checks++;
    if (pc !== 16'h0010 || halted !== 1'b0)
      $display("FAIL halt_preload: got pc=%h halted=%b want pc=0010 halted=0", pc, halted);
    else passed++;
    // A conditional self-jump is an ordinary jump.
    drive(1'b0, 1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 16'h0010);
    checks++;
    if (pc !== 16'h0010 || taken !== 1'b1 || halted !== 1'b0)
      $display("FAIL cond_self_jump: got pc=%h taken=%b halted=%b want pc=0010 taken=1 halted=0",
               pc, taken, halted);
    else passed++;
    // An unconditional self-jump halts.
    drive(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0010);
    checks++;
    if (pc !== 16'h0010 || taken !== 1'b1 || halted !== 1'b1)
      $display("FAIL halt_detect: got pc=%h taken=%b halted=%b want pc=0010 taken=1 halted=1",
               pc, taken, halted);
    else passed++;
    // While halted, jumps, stalls and increments all have no effect.
    drive(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0055);
    drive(1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0055);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (pc !== 16'h0010 || taken !== 1'b1 || halted !== 1'b1)
      $display("FAIL halt_hold: got pc=%h taken=%b halted=%b want pc=0010 taken=1 halted=1",
               pc, taken, halted);
    else passed++;
    drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (pc !== RESET_VEC || taken !== 1'b0 || halted !== 1'b0)
      $display("FAIL halt_reset: got pc=%h taken=%b halted=%b want pc=%h taken=0 halted=0",
               pc, taken, halted, RESET_VEC);
    else passed++;
  endtask

  task automatic test_sweep();
    logic [WIDTH-1:0] exp_pc;
    logic             exp_taken;
    logic             z;
    logic             n;
    logic [2:0]       j;
    logic             c;
    logic [WIDTH-1:0] t;
    int               vec;
    exp_pc = RESET_VEC;
    vec    = 0;
    for (int ji = 0; ji < 8; ji++) begin
      for (int zn = 0; zn < 3; zn++) begin
        for (int ci = 0; ci < 2; ci++) begin
          j = 3'(ji);
          c = 1'(ci);
          z = (zn == 2);
          n = (zn == 1);
          t = exp_pc + 16'h1000;  // never equal to pc, so the sweep never halts
          // Hack jump table: lt uses ng, eq uses zr, gt needs both clear.
          exp_taken = c & ((j[2] & n) | (j[1] & z) | (j[0] & ~z & ~n));
          exp_pc    = exp_taken ? t : exp_pc + 16'h0001;
          drive(1'b0, 1'b1, c, j, z, n, t);
          checks++;
          if (taken !== exp_taken || pc !== exp_pc || halted !== 1'b0)
            $display("FAIL sweep jmp=%b zr=%b ng=%b is_c=%b: got pc=%h taken=%b halted=%b want pc=%h taken=%b halted=0",
                     j, z, n, c, pc, taken, halted, exp_pc, exp_taken);
          else passed++;
          vec++;
          if (vec == 21) begin
            drive(1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0123);
            checks++;
            if (pc !== RESET_VEC || taken !== 1'b0 || halted !== 1'b0)
              $display("FAIL sweep_reset: got pc=%h taken=%b halted=%b want pc=%h taken=0 halted=0",
                       pc, taken, halted, RESET_VEC);
            else passed++;
            exp_pc = RESET_VEC;
          end
        end
      end
    end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    reset  = 1'b1;
    en     = 1'b0;
    is_c   = 1'b0;
    jmp    = 3'b000;
    zr     = 1'b0;
    ng     = 1'b0;
    target = '0;
    test_reset();
    test_increment();
    test_jump_eq();
    test_wrap();
    test_stall();
    test_halt();
    test_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
